// File: rtl/tone_pkg.sv
// Shared types and constants for the tone sequencer: state encoding, ROM field
// widths, end/rest markers and the safe non-zero frequency.
package tone_pkg;

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  localparam int FREQ_W = 16;
  localparam int LEN_W  = 4;
  localparam int DUTY_W = 10;

  localparam logic [LEN_W-1:0]  END_LEN   = '0;
  localparam logic [FREQ_W-1:0] REST_FREQ = '0;
  localparam logic [31:0]       SAFE_FREQ = 32'd1;

  // Counter width that stays at least one bit even for a modulus of 1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tone_if.sv
// Control/status bundle between a melody controller (master) and the
// sequencer (slave); freq/duty go straight on to the PWM stage.
interface tone_if #(parameter int DEPTH = 32);
  import tone_pkg::*;

  logic                     start;
  logic                     stop;
  logic                     loop_en;
  logic [DUTY_W-1:0]        volume;
  logic [31:0]              freq;
  logic [DUTY_W-1:0]        duty;
  logic                     busy;
  logic                     done;
  logic [$clog2(DEPTH)-1:0] note_idx;

  modport master (
    output start, stop, loop_en, volume,
    input  freq, duty, busy, done, note_idx
  );

  modport slave (
    input  start, stop, loop_en, volume,
    output freq, duty, busy, done, note_idx
  );

endinterface

// File: rtl/tone_rom.sv
// Melody ROM: combinational {f, len} lookup by note index.
module tone_rom
  import tone_pkg::*;
#(
  parameter int DEPTH = 32
) (
  input  logic [$clog2(DEPTH)-1:0] idx,
  output logic [FREQ_W-1:0]        f,
  output logic [LEN_W-1:0]         len
);

  always_comb begin
    f   = REST_FREQ;
    len = END_LEN;
    case (int'(idx))
      0: begin f = 16'd440; len = 4'd2; end
      1: begin f = 16'd0;   len = 4'd1; end
      2: begin f = 16'd523; len = 4'd1; end
      default: ;
    endcase
  end

endmodule

// File: rtl/tone_sequencer.sv
// Melody sequencer driving the PWM stage through PLAY/GAP per ROM entry.
// Optional build macro TONE_FADE_EN: duty decays by ~25% on each beat wrap.
module tone_sequencer
  import tone_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int BEAT_HZ = 8,
  parameter int GAP_CYC = 2_000_000,
  parameter int DEPTH   = 32
) (
  input  logic  clk,
  input  logic  rst,
  tone_if.slave bus
);

  localparam int BEAT_CYC = CLK_HZ / BEAT_HZ;
  localparam int SUB_W    = cnt_width(BEAT_CYC);
  localparam int GAP_W    = cnt_width(GAP_CYC);
  localparam int IDX_W    = $clog2(DEPTH);

  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(BEAT_CYC - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DEPTH - 1);

  state_t            state_q, state_d;
  logic [31:0]       freq_q, freq_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic              done_q, done_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [SUB_W-1:0]  sub_q, sub_d;
  logic [LEN_W-1:0]  beat_q, beat_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [GAP_W-1:0]  gap_q, gap_d;

  logic [IDX_W-1:0]  next_idx;
  logic [FREQ_W-1:0] next_f, first_f, load_f;
  logic [LEN_W-1:0]  next_len, first_len, load_len;
  logic              next_ok, first_ok, use_next, load;

  assign next_idx = idx_q + IDX_W'(1);

  tone_rom #(.DEPTH(DEPTH)) u_rom_next (
    .idx (next_idx),
    .f   (next_f),
    .len (next_len)
  );

  tone_rom #(.DEPTH(DEPTH)) u_rom_first (
    .idx ('0),
    .f   (first_f),
    .len (first_len)
  );

  assign next_ok  = (idx_q != IDX_LAST) && (next_len != END_LEN);
  assign first_ok = (first_len != END_LEN);
  assign use_next = (state_q == GAP) && next_ok;
  assign load_f   = use_next ? next_f : first_f;
  assign load_len = use_next ? next_len : first_len;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      freq_q  <= SAFE_FREQ;
      duty_q  <= '0;
      done_q  <= 1'b0;
      idx_q   <= '0;
      sub_q   <= '0;
      beat_q  <= '0;
      len_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      freq_q  <= freq_d;
      duty_q  <= duty_d;
      done_q  <= done_d;
      idx_q   <= idx_d;
      sub_q   <= sub_d;
      beat_q  <= beat_d;
      len_q   <= len_d;
      gap_q   <= gap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    freq_d  = freq_q;
    duty_d  = duty_q;
    done_d  = 1'b0;
    idx_d   = idx_q;
    sub_d   = sub_q;
    beat_d  = beat_q;
    len_d   = len_q;
    gap_d   = gap_q;
    load    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          idx_d = '0;
          if (first_ok) load = 1'b1;
          else          done_d = 1'b1;
        end
      end
      PLAY: begin
        if (bus.stop) begin
          state_d = IDLE;
          duty_d  = '0;
        end else if (sub_q == SUB_LAST) begin
          sub_d = '0;
          if (beat_q + LEN_W'(1) == len_q) begin
            state_d = GAP;
            duty_d  = '0;
            gap_d   = '0;
          end else begin
            beat_d = beat_q + LEN_W'(1);
`ifdef TONE_FADE_EN
            duty_d = duty_q - (duty_q >> 2);
`endif
          end
        end else begin
          sub_d = sub_q + SUB_W'(1);
        end
      end
      GAP: begin
        if (bus.stop) begin
          state_d = IDLE;
          duty_d  = '0;
        end else if (gap_q == GAP_LAST) begin
          // A finished melody wraps to entry 0 when looping, else reports done.
          if (next_ok) begin
            idx_d = next_idx;
            load  = 1'b1;
          end else if (bus.loop_en && first_ok) begin
            idx_d = '0;
            load  = 1'b1;
          end else begin
            state_d = IDLE;
            duty_d  = '0;
            done_d  = 1'b1;
          end
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      state_d = PLAY;
      freq_d  = (load_f == REST_FREQ) ? SAFE_FREQ : {16'd0, load_f};
      duty_d  = (load_f == REST_FREQ) ? '0 : bus.volume;
      sub_d   = '0;
      beat_d  = '0;
      len_d   = load_len;
    end
  end

  assign bus.freq     = freq_q;
  assign bus.duty     = duty_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = done_q;
  assign bus.note_idx = idx_q;

endmodule
